// File: rtl/fwrisc_exec_issue_ctrl.sv
// Issue controller between fwrisc decode and exec: 2-entry bundle FIFO, one bundle in flight.
// Optional hang watchdog is built only when FWRISC_ISSUE_WATCHDOG_EN is defined.
module fwrisc_exec_issue_ctrl #(
    parameter int WDOG_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_instr_c,
    input  logic [4:0]  in_op_type,
    input  logic [31:0] in_op_a,
    input  logic [31:0] in_op_b,
    input  logic [31:0] in_op_c,
    input  logic [5:0]  in_op,
    input  logic [5:0]  in_rd,
    input  logic        flush,
    output logic        decode_valid,
    input  logic        instr_complete,
    output logic        instr_c,
    output logic [4:0]  op_type,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [5:0]  op,
    output logic [31:0] op_c,
    output logic [5:0]  rd,
    output logic        busy,
    output logic        hang
);

    localparam int BW = 1 + 5 + 32 + 32 + 32 + 6 + 6;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state, state_next;
    logic [BW-1:0] fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    count;
    logic          push, pop, dv_r;
    logic [BW-1:0] in_bundle, head;

    assign in_bundle    = {in_instr_c, in_op_type, in_op_a, in_op_b, in_op_c, in_op, in_rd};
    assign head         = fifo_mem[rd_ptr];
    assign in_ready     = (count != 2'd2) && !flush;
    assign push         = in_valid && in_ready;
    assign decode_valid = dv_r && !instr_complete;
    assign busy         = (state == BUSY) || (count != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Issue only from IDLE so exec always sees a low decode_valid cycle between bundles.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0 && !flush) begin
                    pop        = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (instr_complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_bundle;
        end
    end

    // Bundle registers load only on pop, so they stay stable for the whole BUSY period.
    always_ff @(posedge clock) begin
        if (reset) begin
            dv_r    <= 1'b0;
            instr_c <= 1'b0;
            op_type <= 5'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_c    <= 32'd0;
            op      <= 6'd0;
            rd      <= 6'd0;
        end else if (pop) begin
            dv_r <= 1'b1;
            {instr_c, op_type, op_a, op_b, op_c, op, rd} <= head;
        end else if (state == BUSY && instr_complete) begin
            dv_r <= 1'b0;
        end
    end

`ifdef FWRISC_ISSUE_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt;
    logic        hang_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            wdog_cnt <= 16'd0;
            hang_r   <= 1'b0;
        end else if (pop) begin
            wdog_cnt <= 16'd0;
        end else if (state == BUSY && !instr_complete) begin
            if (wdog_cnt == WDOG_LIMIT) begin
                hang_r <= 1'b1;
            end
            if (wdog_cnt != 16'hFFFF) begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end
        end
    end

    assign hang = hang_r;
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES != 0);
    assign hang        = 1'b0;
`endif

endmodule

// File: doc/fwrisc_exec_issue_ctrl.md
# fwrisc_exec_issue_ctrl

Issue controller between the fwrisc decode stage and the exec unit. Buffers up to two decoded instruction bundles and presents them to exec one at a time using the exec handshake: `decode_valid` is held until `instr_complete`. Supports flushing queued (not yet issued) instructions on redirect. An optional watchdog flags an exec unit that never completes.

## Interface
Parameters:
- WDOG_CYCLES, 64, cycles in BUSY without `instr_complete` before `hang` asserts (legal range 2..65535)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded bundle available
- in_ready  out  1  controller accepts bundle this cycle
- in_instr_c  in  1  compressed-instruction flag
- in_op_type  in  5  op type (fwrisc_op_type encoding)
- in_op_a / in_op_b / in_op_c  in  32 each  operands / branch offset
- in_op  in  6  ALU op (fwrisc_alu_op encoding)
- in_rd  in  6  destination register
- flush  in  1  discard all queued bundles
- decode_valid  out  1  bundle valid to exec
- instr_complete  in  1  exec finished current bundle
- instr_c, op_type, op_a, op_b, op, op_c, rd  out  same widths as in_*  registered bundle to exec
- busy  out  1  bundle in flight or queued
- hang  out  1  watchdog tripped (sticky)

## Operation
- 2-entry FIFO, count 0..2, wrap-around pointers. Push when `in_valid && in_ready`; `in_ready = (count<2) && !flush`.
- FSM, two states:
  - IDLE: if count>0 and !flush: pop head into output registers, set `dv_r`=1, go BUSY. Otherwise stay.
  - BUSY: if `instr_complete`: `dv_r`<=0, go IDLE. Otherwise hold.
- `decode_valid = dv_r && !instr_complete` (combinational drop in the completion cycle).
- Output bundle registers change only on pop; stable throughout BUSY.
- Push and pop in the same cycle: count unchanged; pop takes the old head. A push into an empty FIFO is not issued until the next cycle.
- flush: count<=0 next cycle, pointers reset; same-cycle push is blocked by `in_ready`=0; IDLE issue is suppressed. The in-flight bundle is not aborted: BUSY continues until `instr_complete`.
- `instr_complete` in IDLE: ignored.
- `busy = (state==BUSY) || (count!=0)`.
- Reset, including mid-operation: state IDLE, count 0, `dv_r` 0, all bundle outputs 0, `hang` 0, watchdog counter 0. A bundle in flight is dropped.

## Timing
- Latency from accepted push into an empty idle controller to `decode_valid`=1: 2 cycles (push cycle N, pop in IDLE at N+1, `decode_valid` at N+2).
- Between instructions, `decode_valid` is low for at least one full cycle (the IDLE cycle). Throughput is at most one instruction per (exec latency + 2) cycles.
- Watchdog counter is 16 bits. It clears on entering BUSY and increments each BUSY cycle without `instr_complete`. When the count reaches WDOG_CYCLES-1, `hang`<=1 the next cycle and stays high until reset.

## Configuration
- `FWRISC_ISSUE_WATCHDOG_EN`: when defined, the watchdog counter and `hang` are implemented as described. When undefined, there is no counter, `hang` is tied to 0, and WDOG_CYCLES has no effect.

## Test plan
- Reset, then push op_type=BRANCH, op=OP_EQ, op_a=op_b=0x1234, op_c=8 at cycle N; exec completes at N+4. Required: `decode_valid` high N+2..N+3, low at N+4; outputs hold the pushed values; `busy` 0 at N+5.
- Push 3 bundles back-to-back while exec stalls. Required: `in_ready`=0 once count=2; issue order matches push order; each issue preceded by one IDLE cycle.
- Queue 2 bundles while exec is busy, assert `flush` with `in_valid`=1. Required: the current bundle completes normally; no further `decode_valid`; the flushed and blocked bundles are never issued.
- Assert reset while in BUSY with 2 queued bundles. Required: next cycle all outputs 0, `busy` 0, `in_ready` 1.
- With the macro defined and WDOG_CYCLES=8, issue a bundle and never complete it. Required: `hang` rises 8 cycles after entering BUSY and stays high through a later `instr_complete`. Without the macro: `hang` stays 0.
- Hold `instr_complete`=1 in IDLE with an empty FIFO. Required: no state change, `decode_valid` 0.
